// File: rtl/bcd_calc_pkg.sv
// Shared types and constants for the two-digit BCD calculator front end.
package bcd_calc_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EVAL = 2'd2,
    S_RES  = 2'd3
  } state_t;

  localparam logic [3:0] DEF_KEY_PLUS = 4'hA;
  localparam logic [3:0] DEF_KEY_EQ   = 4'hE;
  localparam logic [3:0] DEF_KEY_CLR  = 4'hC;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_adder_8bit.sv
// Two-digit BCD adder; combinational, with decimal carry out.
module bcd_adder_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] SUM_BCD,
  output logic       CARRY_OUT
);

  logic [4:0] u_raw;
  logic [4:0] t_raw;
  logic       c_u;
  logic       c_t;
  logic [3:0] u_dig;
  logic [3:0] t_dig;

  always_comb begin
    u_raw     = {1'b0, A[3:0]} + {1'b0, B[3:0]};
    c_u       = u_raw > 5'd9;
    u_dig     = c_u ? (u_raw[3:0] + 4'd6) : u_raw[3:0];
    t_raw     = {1'b0, A[7:4]} + {1'b0, B[7:4]} + {4'b0000, c_u};
    c_t       = t_raw > 5'd9;
    t_dig     = c_t ? (t_raw[3:0] + 4'd6) : t_raw[3:0];
    SUM_BCD   = {t_dig, u_dig};
    CARRY_OUT = c_t;
  end

endmodule

// File: rtl/bcd_operand_reg.sv
// Two-digit BCD operand shift register with digit count; clear > load > shift.
module bcd_operand_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [1:0] load_cnt,
  input  logic       shift,
  input  logic [3:0] digit,
  output logic [7:0] value,
  output logic [1:0] count,
  output logic       full
);

  assign full = (count == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (load) begin
      value <= load_val;
      count <= load_cnt;
    end else if (shift && !full) begin
      value <= {value[3:0], digit};
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/bcd_operand_entry.sv
// Keypad operand sequencer: builds BCD operands A/B, captures adder result on "=".
module bcd_operand_entry
  import bcd_calc_pkg::*;
#(
  parameter logic [3:0] KEY_PLUS = DEF_KEY_PLUS,
  parameter logic [3:0] KEY_EQ   = DEF_KEY_EQ,
  parameter logic [3:0] KEY_CLR  = DEF_KEY_CLR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic [7:0]  A,
  output logic [7:0]  B,
  input  logic [7:0]  SUM_BCD,
  input  logic        CARRY_IN,
  output logic        result_valid,
  output logic        err,
  output logic [11:0] disp_bcd,
  output logic [1:0]  state
);

  state_t     state_q, state_d;
  logic [8:0] res_q, res_d;
  logic       rv_d, err_d;
  logic       accept;

  logic       a_clear, a_load, a_shift, a_full;
  logic [7:0] a_load_val;
  logic [1:0] a_load_cnt, a_count;
  logic       b_clear, b_shift, b_full;
  logic [1:0] b_count;

  assign key_ready = (state_q != S_EVAL);
  assign accept    = key_valid && key_ready;
  assign state     = state_q;

  bcd_operand_reg u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (a_clear),
    .load     (a_load),
    .load_val (a_load_val),
    .load_cnt (a_load_cnt),
    .shift    (a_shift),
    .digit    (key_code),
    .value    (A),
    .count    (a_count),
    .full     (a_full)
  );

  bcd_operand_reg u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (b_clear),
    .load     (1'b0),
    .load_val ('0),
    .load_cnt ('0),
    .shift    (b_shift),
    .digit    (key_code),
    .value    (B),
    .count    (b_count),
    .full     (b_full)
  );

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    rv_d       = result_valid;
    err_d      = 1'b0;
    a_clear    = 1'b0;
    a_load     = 1'b0;
    a_load_val = '0;
    a_load_cnt = '0;
    a_shift    = 1'b0;
    b_clear    = 1'b0;
    b_shift    = 1'b0;

    if (state_q == S_EVAL) begin
      res_d   = {CARRY_IN, SUM_BCD};
      rv_d    = 1'b1;
      state_d = S_RES;
    end else if (accept) begin
      if (key_code == KEY_CLR) begin
        a_clear = 1'b1;
        b_clear = 1'b1;
        res_d   = '0;
        rv_d    = 1'b0;
        state_d = S_A;
      end else begin
        unique case (state_q)
          S_A: begin
            if (is_digit(key_code)) begin
              if (a_full) err_d = 1'b1;
              else        a_shift = 1'b1;
            end else if (key_code == KEY_PLUS) begin
              b_clear = 1'b1;
              state_d = S_B;
            end else begin
              err_d = 1'b1;
            end
          end
          S_B: begin
            if (is_digit(key_code)) begin
              if (b_full) err_d = 1'b1;
              else        b_shift = 1'b1;
            end else if (key_code == KEY_EQ) begin
              state_d = S_EVAL;
            end else begin
              err_d = 1'b1;
            end
          end
          S_RES: begin
            if (is_digit(key_code)) begin
              a_load     = 1'b1;
              a_load_val = {4'h0, key_code};
              a_load_cnt = 2'd1;
              b_clear    = 1'b1;
              rv_d       = 1'b0;
              state_d    = S_A;
            end else if (key_code == KEY_PLUS && !res_q[8]) begin
              // Chain: previous result becomes a full two-digit A
              a_load     = 1'b1;
              a_load_val = res_q[7:0];
              a_load_cnt = 2'd2;
              b_clear    = 1'b1;
              rv_d       = 1'b0;
              state_d    = S_B;
            end else begin
              err_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_A;
      res_q        <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      res_q        <= res_d;
      result_valid <= rv_d;
      err          <= err_d;
    end
  end

  always_comb begin
    disp_bcd = '0;
    unique case (state_q)
      S_A:     disp_bcd = {4'h0, A};
      S_B:     disp_bcd = {4'h0, B};
      S_EVAL:  disp_bcd = {4'h0, B};
      S_RES:   disp_bcd = {3'b000, res_q};
      default: disp_bcd = '0;
    endcase
  end

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Self-checking bench for bcd_operand_entry with a decimal-arithmetic reference model.
module tb_bcd_operand_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        key_ready;
  logic [7:0]  A, B, SUM_BCD;
  logic        CARRY_OUT;
  logic        result_valid, err;
  logic [11:0] disp_bcd;
  logic [1:0]  state;

  int n_checks = 0;
  int failures = 0;

  // Reference model: operands kept as plain decimal integers
  int m_a, m_acnt, m_b, m_bcnt, m_res, m_st;
  bit m_rv, m_err;

  always #5 clk = ~clk;

  bcd_operand_entry #(.KEY_PLUS(4'hA), .KEY_EQ(4'hE), .KEY_CLR(4'hC)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .A(A), .B(B), .SUM_BCD(SUM_BCD), .CARRY_IN(CARRY_OUT),
    .result_valid(result_valid), .err(err), .disp_bcd(disp_bcd), .state(state)
  );

  bcd_adder_8bit adder (.A(A), .B(B), .SUM_BCD(SUM_BCD), .CARRY_OUT(CARRY_OUT));

  function automatic logic [7:0] bcd2(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [11:0] bcd3(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [11:0] m_disp();
    if (m_st == 0) return {4'h0, bcd2(m_a)};
    if (m_st == 3) return bcd3(m_res);
    return {4'h0, bcd2(m_b)};
  endfunction

  task automatic model_reset();
    m_a = 0; m_acnt = 0; m_b = 0; m_bcnt = 0; m_res = 0; m_st = 0; m_rv = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input int c);
    m_err = 0;
    if (m_st == 2) begin
      m_res = m_a + m_b; m_rv = 1; m_st = 3;
    end else if (v) begin
      if (c == 12) model_reset();
      else if (c <= 9) begin
        if (m_st == 3) begin
          m_a = c; m_acnt = 1; m_b = 0; m_bcnt = 0; m_rv = 0; m_st = 0;
        end else if (m_st == 0) begin
          if (m_acnt == 2) m_err = 1;
          else begin m_a = (m_a % 10) * 10 + c; m_acnt++; end
        end else begin
          if (m_bcnt == 2) m_err = 1;
          else begin m_b = (m_b % 10) * 10 + c; m_bcnt++; end
        end
      end else if (c == 10) begin
        if (m_st == 0) begin m_b = 0; m_bcnt = 0; m_st = 1; end
        else if (m_st == 3 && m_res < 100) begin
          m_a = m_res; m_acnt = 2; m_b = 0; m_bcnt = 0; m_rv = 0; m_st = 1;
        end else m_err = 1;
      end else if (c == 14) begin
        if (m_st == 1) m_st = 2;
        else m_err = 1;
      end else m_err = 1;
    end
  endtask

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk);
    model_step(1'b1, int'(c));
    #1;
    key_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    key_valid = 1'b0;
    @(posedge clk);
    model_step(1'b0, 0);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({A, B, disp_bcd, state, result_valid, err, key_ready} !== {8'h00, 8'h00, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset got A=%h B=%h disp=%h st=%0d rv=%b err=%b rdy=%b exp all zero rdy=1",
               A, B, disp_bcd, state, result_valid, err, key_ready);
    end
  endtask

  task automatic test_basic_add();
    press(4); press(7); press(4'hA); press(5); press(8);
    n_checks++;
    if ({A, B} !== {8'h47, 8'h58}) begin
      failures++; $display("FAIL basic_operands got A=%h B=%h exp A=47 B=58", A, B);
    end
    press(4'hE);
    n_checks++;
    if ({state, key_ready, disp_bcd} !== {2'd2, 1'b0, 12'h058}) begin
      failures++; $display("FAIL basic_eval got st=%0d rdy=%b disp=%h exp st=2 rdy=0 disp=058", state, key_ready, disp_bcd);
    end
    idle();
    n_checks++;
    if ({state, result_valid, disp_bcd} !== {2'd3, 1'b1, 12'h105}) begin
      failures++; $display("FAIL basic_result got st=%0d rv=%b disp=%h exp st=3 rv=1 disp=105", state, result_valid, disp_bcd);
    end
    press(4'hC);
  endtask

  task automatic test_third_digit();
    press(1);
    n_checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL third_err1 got=%b exp=0", err); end
    press(2); press(3);
    n_checks++;
    if ({A, err} !== {8'h12, 1'b1}) begin
      failures++; $display("FAIL third_digit got A=%h err=%b exp A=12 err=1", A, err);
    end
    press(9);
    n_checks++;
    if ({A, err} !== {8'h12, 1'b1}) begin
      failures++; $display("FAIL count_held got A=%h err=%b exp A=12 err=1", A, err);
    end
    idle();
    n_checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_pulse_width got=%b exp=0", err); end
    press(4'hC);
  endtask

  task automatic test_chaining();
    press(2); press(5); press(4'hA); press(1); press(7); press(4'hE); idle();
    n_checks++;
    if (disp_bcd !== 12'h042) begin failures++; $display("FAIL chain_res1 got=%h exp=042", disp_bcd); end
    press(4'hA);
    n_checks++;
    if ({A, B, state, result_valid} !== {8'h42, 8'h00, 2'd1, 1'b0}) begin
      failures++; $display("FAIL chain_load got A=%h B=%h st=%0d rv=%b exp A=42 B=00 st=1 rv=0", A, B, state, result_valid);
    end
    press(9); press(9); press(4'hE); idle();
    n_checks++;
    if (disp_bcd !== 12'h141) begin failures++; $display("FAIL chain_res2 got=%h exp=141", disp_bcd); end
    press(4'hA);
    n_checks++;
    if ({err, state, disp_bcd} !== {1'b1, 2'd3, 12'h141}) begin
      failures++; $display("FAIL chain_overflow got err=%b st=%0d disp=%h exp err=1 st=3 disp=141", err, state, disp_bcd);
    end
    press(4'hC);
  endtask

  task automatic test_clear();
    press(3); press(4'hA); press(6); press(4'hC);
    n_checks++;
    if ({A, B, state, disp_bcd, err} !== {8'h00, 8'h00, 2'd0, 12'h000, 1'b0}) begin
      failures++; $display("FAIL clear got A=%h B=%h st=%0d disp=%h err=%b exp all zero", A, B, state, disp_bcd, err);
    end
  endtask

  task automatic test_stall_reset();
    press(1); press(4'hA); press(2); press(4'hE);
    press(5);
    n_checks++;
    if ({B, state, err, disp_bcd} !== {8'h02, 2'd3, 1'b0, 12'h003}) begin
      failures++; $display("FAIL stall_drop got B=%h st=%0d err=%b disp=%h exp B=02 st=3 err=0 disp=003", B, state, err, disp_bcd);
    end
    press(3); press(4'hA); press(4); press(4'hE);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({A, B, disp_bcd, state, result_valid, err, key_ready} !== {8'h00, 8'h00, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset got A=%h B=%h disp=%h st=%0d rv=%b err=%b rdy=%b exp all zero rdy=1",
               A, B, disp_bcd, state, result_valid, err, key_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rejected();
    logic [3:0] bad [3] = '{4'hB, 4'hD, 4'hF};
    press(1); press(4'hE);
    n_checks++;
    if ({err, A, state} !== {1'b1, 8'h01, 2'd0}) begin
      failures++; $display("FAIL eq_in_a got err=%b A=%h st=%0d exp err=1 A=01 st=0", err, A, state);
    end
    for (int s = 0; s < 3; s++) begin
      if (s == 1) press(4'hA);
      if (s == 2) begin press(2); press(4'hE); idle(); end
      for (int i = 0; i < 3; i++) begin
        logic [7:0] a0, b0;
        logic [1:0] s0;
        a0 = A; b0 = B; s0 = state;
        press(bad[i]);
        n_checks++;
        if ({err, A, B, state} !== {1'b1, a0, b0, s0}) begin
          failures++;
          $display("FAIL invalid_code_%h got err=%b A=%h B=%h st=%0d exp err=1 A=%h B=%h st=%0d",
                   bad[i], err, A, B, state, a0, b0, s0);
        end
      end
    end
    press(4'hC);
  endtask

  task automatic test_random();
    logic [32:0] got, exp;
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55)      press(4'($urandom_range(0, 9)));
      else if (r < 70) press(4'hA);
      else if (r < 82) press(4'hE);
      else if (r < 85) press(4'hC);
      else if (r < 92) begin
        case ($urandom_range(0, 2))
          0: press(4'hB);
          1: press(4'hD);
          default: press(4'hF);
        endcase
      end else idle();
      got = {A, B, disp_bcd, state, result_valid, err, key_ready};
      exp = {bcd2(m_a), bcd2(m_b), m_disp(), 2'(m_st), m_rv, m_err, (m_st != 2)};
      n_checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random_%0d got {A,B,disp,st,rv,err,rdy}=%h exp=%h", n, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_third_digit();
    test_chaining();
    test_clear();
    test_stall_reset();
    test_rejected();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_operand_entry.md
# bcd_operand_entry

Keypad-facing operand sequencer for the two-digit BCD calculator, directly upstream of `bcd_adder_8bit`. It accepts key codes one at a time and shifts digits into two-digit BCD operands A and B, which drive the adder combinationally. It also captures the adder's SUM_BCD/CARRY_OUT on "=" and presents a three-digit BCD display value. Supported operation is addition only, with chaining from the previous result.

## Interface
Parameters:
- KEY_PLUS, default 4'hA: key code for "+".
- KEY_EQ, default 4'hE: key code for "=".
- KEY_CLR, default 4'hC: key code for "clear".

Ports:
- clk, input, 1: single system clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- key_valid, input, 1: key_code is valid this cycle.
- key_code, input, 4: 0–9 are digits, plus KEY_PLUS / KEY_EQ / KEY_CLR. All other codes are invalid.
- key_ready, output, 1: block can accept a key. A key is accepted when key_valid && key_ready.
- A, output, 8: operand A, BCD {tens, units}. Goes to adder A.
- B, output, 8: operand B, BCD. Goes to adder B.
- SUM_BCD, input, 8: adder sum.
- CARRY_IN, input, 1: adder CARRY_OUT.
- result_valid, output, 1: a captured result is being shown.
- err, output, 1: one-cycle pulse when an accepted key is rejected.
- disp_bcd, output, 12: {hundreds, tens, units} for the display stage.
- state, output, 2: current FSM state, for debug.

## Operation
- **States:** S_A=0 (enter A), S_B=1 (enter B), S_EVAL=2, S_RES=3.
- **Per-operand digit counter (0..2):**
  - A digit with count<2 sets operand <= {operand[3:0], digit} and increments the count.
  - A digit with count==2 leaves the operand unchanged and pulses err.
- **S_A:**
  - Digit: shifts into A.
  - KEY_PLUS: goes to S_B with B=0 and B count=0.
  - KEY_EQ: rejected (err).
- **S_B:**
  - Digit: shifts into B.
  - KEY_EQ: goes to S_EVAL.
  - KEY_PLUS: rejected (err).
- **S_EVAL:**
  - Lasts exactly one cycle, with key_ready=0.
  - Captures res <= {CARRY_IN, SUM_BCD} (9 bits), sets result_valid=1 and goes to S_RES.
- **S_RES:**
  - Digit: A <= {4'h0, digit}, A count=1, B=0, result_valid=0, goes to S_A.
  - KEY_PLUS with res[8]==0: A <= res[7:0], A count=2, B=0, B count=0, result_valid=0, goes to S_B.
  - KEY_PLUS with res[8]==1 (overflow ≥100): rejected (err), stays in S_RES.
  - KEY_EQ: rejected (err), state unchanged.
- **KEY_CLR, in any state where key_ready=1:** synchronous return to reset values. err=0.
- **Invalid codes (B, D, F when parameters are at defaults):** rejected (err), no other change.
- **disp_bcd** is a combinational function of registered state only, with no path from key inputs:
  - S_A: {4'h0, A}.
  - S_B: {4'h0, B}.
  - S_EVAL: {4'h0, B}.
  - S_RES: {3'b000, res[8], res[7:0]}.

## Timing
- **Reset values:**
  - state=S_A, counts=0, res=0.
  - A=8'h00, B=8'h00, result_valid=0, err=0.
  - disp_bcd=12'h000, key_ready=1.
  - Asserting rst_n low at any point, including S_EVAL, forces these values immediately.
- **Digit latency:** a key accepted at edge N updates A/B/state at edge N; err is high for the cycle after edge N only.
- **EQ latency:**
  - KEY_EQ accepted at edge N puts the FSM in S_EVAL after N.
  - The adder settles combinationally from the registered A/B.
  - res is captured at edge N+1; result_valid and the new disp_bcd are visible after N+1.
- **key_ready:** 0 only in S_EVAL. key_valid while key_ready=0 is dropped, with no err and no change. The source must hold or re-present the key.
- **No back-pressure elsewhere.** One key per cycle is sustainable.
- **A/B are stable** except on accepted-key edges and reset.

## Structure
- Package bcd_calc_pkg:
  - state enum (S_A, S_B, S_EVAL, S_RES).
  - Default key-code constants (KEY_PLUS, KEY_EQ, KEY_CLR).
  - Digit-range check function (code ≤ 9).
- Sub-module bcd_operand_reg:
  - Two-digit BCD shift register with a 2-bit digit count.
  - Inputs: shift, load, clear.
  - Flags: full.
  - Instantiated twice, for A and B.
- Top-level holds the FSM, res register, err pulse and display mux.
- Bench instantiates `bcd_adder_8bit` alongside, connecting A/B to its inputs and SUM_BCD/CARRY_OUT back.

## Test plan
- **Basic add with overflow:** keys 4,7,+,5,8,= -> A=8'h47, B=8'h58; one cycle after EQ, result_valid=1 and disp_bcd=12'h105.
- **Third digit rejected:** keys 1,2,3 in S_A -> A=8'h12, err pulse on "3" only, digit count stays 2.
- **Chaining:**
  - Keys 2,5,+,1,7,=,+ -> disp_bcd=12'h042, then A=8'h42, B=8'h00, state=S_B.
  - Continue with 9,9,=,+ -> disp_bcd=12'h141, err pulse on "+", state stays S_RES.
- **Clear mid-entry:** keys 3,+,6,C -> A=B=8'h00, state=S_A, disp_bcd=12'h000, no err.
- **Stall and async reset:**
  - key_valid=1 with code 5 during S_EVAL -> dropped (key_ready=0), B unchanged.
  - rst_n=0 asserted mid S_EVAL -> all outputs at reset values before the next edge.
- **Rejected keys:** "=" in S_A, codes 4'hB/4'hD/4'hF in any state -> err pulse, A/B/state unchanged.
